// File: rtl/irqc_pkg.sv
// irqc_pkg -- shared definitions for the interrupt controller.
//
// Holds the register offsets of the 4-word bus window (word index taken
// from dmem_addr[3:2]), the controller state encoding (the encoding is
// exposed to software through STATUS[4:3]) and the "no interrupt" code.
package irqc_pkg;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_MASK    = 2'd1;
   localparam logic [1:0] REG_EOI     = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   localparam logic [2:0] NO_IRQ = 3'd0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GAP    = 2'd2
   } irqc_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc -- combinational 7-to-3 priority encoder.
//
// Ports:
//   req_i  [6:0]  request vector, bit i is source number i+1
//   code_o [2:0]  (highest set index)+1, or 0 when no bit is set
module irq_prio_enc (
   input  logic [6:0] req_i,
   output logic [2:0] code_o
);

   // Scan upward so that a higher set bit overwrites any lower one,
   // leaving the highest-numbered request as the result.
   always_comb begin
      code_o = 3'd0;
      for (int i = 0; i < 7; i++) begin
         if (req_i[i]) begin
            code_o = 3'(i + 1);
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// irq_controller -- memory-mapped 7-source interrupt controller.
//
// Sources are edge-detected into PENDING; the highest-numbered pending and
// unmasked source is presented to the core as a registered code on IRQ and
// held until software acknowledges it with a matching EOI write. A one-cycle
// GAP with IRQ = 0 follows every acknowledge.
//
// Register window (BASE_ADDR, word offsets from dmem_addr[3:2]):
//   0 PENDING (RO)  1 MASK (RW)  2 EOI (WO, reads 0)
//   3 STATUS  (RO)  {27'b0, state[1:0], IRQ[2:0]}
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   src  [6:0] interrupt sources, bit i is source i+1
//   dmem_addr  core data-bus address
//   dmem_we    core data-bus write enable
//   dmem_wd    core data-bus write data
//   rd_data    combinational read data, 0 when not selected
//   sel        combinational window hit
//   IRQ  [2:0] registered interrupt code (0 = none)
//
// Configuration macro: IRQC_SYNC_EN -- when defined, src passes through a
// two-flop synchronizer before edge detection (2 extra cycles of latency).
module irq_controller
   import irqc_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  src,
   input  logic [31:0] dmem_addr,
   input  logic        dmem_we,
   input  logic [31:0] dmem_wd,
   output logic [31:0] rd_data,
   output logic        sel,
   output logic [2:0]  IRQ
);

   logic [6:0]  srcSampled;
   logic [6:0]  srcPrev_q;
   logic [6:0]  pending_q, pending_d;
   logic [6:0]  mask_q, mask_d;
   logic [2:0]  irq_q, irq_d;
   irqc_state_t state_q, state_d;
   logic [2:0]  candidate;
   logic [1:0]  regSel;
   logic        busWrite;
   logic        eoiHit;
   logic [6:0]  riseBits;
   logic [6:0]  clearBits;
   logic        unusedBits;

   assign sel      = (dmem_addr[31:4] == BASE_ADDR[31:4]);
   assign regSel   = dmem_addr[2 +: 2];
   assign busWrite = sel && dmem_we;

   // Byte-lane bits and upper write-data bits carry no meaning here.
   assign unusedBits = ^{dmem_addr[1:0], dmem_wd[31:7]};

`ifdef IRQC_SYNC_EN
   logic [6:0] sync1_q, sync2_q;

   // Two-flop synchronizer for asynchronous sources; cleared on reset so
   // a source already high at release is still seen as a rising edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= src;
         sync2_q <= sync1_q;
      end
   end

   assign srcSampled = sync2_q;
`else
   assign srcSampled = src;
`endif

   assign riseBits = srcSampled & ~srcPrev_q;

   irq_prio_enc uPrioEnc (
      .req_i  (pending_q & mask_q),
      .code_o (candidate)
   );

   // An acknowledge only counts in ACTIVE and only for the code currently
   // being presented; anything else on the EOI register is dropped.
   assign eoiHit = busWrite && (regSel == REG_EOI) && (state_q == ACTIVE)
                   && (dmem_wd[2:0] == irq_q);

   // Next-state and IRQ code. IRQ is frozen through ACTIVE, so neither a
   // higher-priority arrival nor masking the active source disturbs it.
   always_comb begin
      state_d   = state_q;
      irq_d     = irq_q;
      clearBits = '0;
      case (state_q)
         IDLE: begin
            if (candidate != NO_IRQ) begin
               irq_d   = candidate;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (eoiHit) begin
               clearBits = 7'b1 << (irq_q - 3'd1);
               irq_d     = NO_IRQ;
               state_d   = GAP;
            end
         end
         GAP: begin
            irq_d   = NO_IRQ;
            state_d = IDLE;
         end
         default: begin
            irq_d   = NO_IRQ;
            state_d = IDLE;
         end
      endcase
   end

   // Pending/mask update. OR-ing the new edges in after the clear lets a
   // fresh edge survive an EOI landing on the same bit in the same cycle.
   always_comb begin
      pending_d = (pending_q & ~clearBits) | riseBits;
      mask_d    = mask_q;
      if (busWrite && (regSel == REG_MASK)) begin
         mask_d = dmem_wd[6:0];
      end
   end

   // State registers; reset also drops any interrupt in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         srcPrev_q <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         irq_q     <= NO_IRQ;
         state_q   <= IDLE;
      end else begin
         srcPrev_q <= srcSampled;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         irq_q     <= irq_d;
         state_q   <= state_d;
      end
   end

   // Read mux; unselected accesses and the EOI register read as 0.
   always_comb begin
      rd_data = '0;
      if (sel) begin
         case (regSel)
            REG_PENDING: rd_data = {25'b0, pending_q};
            REG_MASK:    rd_data = {25'b0, mask_q};
            REG_EOI:     rd_data = '0;
            REG_STATUS:  rd_data = {27'b0, state_q, irq_q};
            default:     rd_data = '0;
         endcase
      end
   end

   assign IRQ = irq_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller -- directed self-checking bench for irq_controller.
// Inputs change 2 time units after a rising edge; outputs are read in the
// same window, well clear of the next edge.
module tb_irq_controller;

   localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef IRQC_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   localparam logic [1:0] OFF_PENDING = 2'd0;
   localparam logic [1:0] OFF_MASK    = 2'd1;
   localparam logic [1:0] OFF_EOI     = 2'd2;
   localparam logic [1:0] OFF_STATUS  = 2'd3;

   logic        clk;
   logic        rst_n;
   logic [6:0]  src;
   logic [31:0] dmem_addr;
   logic        dmem_we;
   logic [31:0] dmem_wd;
   logic [31:0] rd_data;
   logic        sel;
   logic [2:0]  IRQ;

   int compared   = 0;
   int mismatched = 0;

   irq_controller #(.BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src       (src),
      .dmem_addr (dmem_addr),
      .dmem_we   (dmem_we),
      .dmem_wd   (dmem_wd),
      .rd_data   (rd_data),
      .sel       (sel),
      .IRQ       (IRQ)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Advance past one rising edge into the quiet window after it.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // One bus write spanning exactly one rising edge.
   task automatic applyStimulus(input logic [1:0] off, input logic [31:0] data);
      dmem_addr = BASE | {28'b0, off, 2'b00};
      dmem_we   = 1'b1;
      dmem_wd   = data;
      step();
      dmem_we   = 1'b0;
      dmem_wd   = '0;
      dmem_addr = '0;
   endtask

   // Combinational register read followed by a comparison.
   task automatic checkReg(input string tag, input logic [1:0] off,
                           input logic [31:0] expected);
      logic [31:0] value;
      dmem_addr = BASE | {28'b0, off, 2'b00};
      #1;
      value = rd_data;
      dmem_addr = '0;
      checkOutput(tag, value, expected);
   endtask

   task automatic pulseSrc(input logic [6:0] bits);
      src = bits;
      step();
      src = '0;
      repeat (LAT) step();
   endtask

   initial begin
      rst_n     = 1'b0;
      src       = '0;
      dmem_addr = '0;
      dmem_we   = 1'b0;
      dmem_wd   = '0;
      step();
      step();

      // Reset state and window decode.
      checkOutput("rst_irq", {29'b0, IRQ}, 32'd0);
      checkReg("rst_status", OFF_STATUS, 32'h0);
      checkReg("rst_mask", OFF_MASK, 32'h0);
      dmem_addr = 32'h1234_5678;
      #1;
      checkOutput("unsel_sel", {31'b0, sel}, 32'd0);
      checkOutput("unsel_rd", rd_data, 32'd0);
      dmem_addr = '0;
      rst_n = 1'b1;

      // Single source: src[2] -> PENDING 0x04, IRQ 3 one cycle later.
      applyStimulus(OFF_MASK, 32'h7F);
      checkReg("mask_rb", OFF_MASK, 32'h7F);
      pulseSrc(7'h04);
      checkReg("t1_pending", OFF_PENDING, 32'h04);
      checkOutput("t1_irq_pre", {29'b0, IRQ}, 32'd0);
      step();
      checkOutput("t1_irq", {29'b0, IRQ}, 32'd3);
      checkReg("t1_status", OFF_STATUS, 32'h0B);

      // Mismatched EOI ignored, matching EOI clears and enters GAP.
      applyStimulus(OFF_EOI, 32'd5);
      checkOutput("t3_bad_eoi_irq", {29'b0, IRQ}, 32'd3);
      checkReg("t3_bad_eoi_pend", OFF_PENDING, 32'h04);
      applyStimulus(OFF_EOI, 32'd3);
      checkOutput("t3_eoi_irq", {29'b0, IRQ}, 32'd0);
      checkReg("t3_eoi_pend", OFF_PENDING, 32'h00);
      checkReg("t3_gap_status", OFF_STATUS, 32'h10);
      step();
      checkReg("t3_idle_status", OFF_STATUS, 32'h00);

      // Two simultaneous sources: 7 first, then 1 after the GAP.
      pulseSrc(7'h41);
      checkReg("t2_pending", OFF_PENDING, 32'h41);
      step();
      checkOutput("t2_irq7", {29'b0, IRQ}, 32'd7);
      applyStimulus(OFF_EOI, 32'd7);
      checkOutput("t2_gap_irq", {29'b0, IRQ}, 32'd0);
      checkReg("t2_gap_status", OFF_STATUS, 32'h10);
      step();
      checkReg("t2_idle_status", OFF_STATUS, 32'h00);
      step();
      checkOutput("t2_irq1", {29'b0, IRQ}, 32'd1);
      checkReg("t2_status1", OFF_STATUS, 32'h09);
      applyStimulus(OFF_EOI, 32'd1);
      step();

      // Masked source stays pending; unmasking raises IRQ 5 a cycle later.
      applyStimulus(OFF_MASK, 32'h00);
      pulseSrc(7'h10);
      checkReg("t4_pending", OFF_PENDING, 32'h10);
      step();
      checkOutput("t4_masked_irq", {29'b0, IRQ}, 32'd0);
      applyStimulus(OFF_MASK, 32'h10);
      checkOutput("t4_unmask_irq0", {29'b0, IRQ}, 32'd0);
      step();
      checkOutput("t4_irq5", {29'b0, IRQ}, 32'd5);
      applyStimulus(OFF_EOI, 32'd5);
      step();

      // New edge coinciding with its own EOI: set wins.
      applyStimulus(OFF_MASK, 32'h7F);
      pulseSrc(7'h02);
      step();
      checkOutput("t5_irq2", {29'b0, IRQ}, 32'd2);
      src = 7'h02;
      repeat (LAT) step();
      applyStimulus(OFF_EOI, 32'd2);
      src = '0;
      checkOutput("t5_gap_irq", {29'b0, IRQ}, 32'd0);
      checkReg("t5_pending", OFF_PENDING, 32'h02);
      step();
      step();
      checkOutput("t5_irq2_again", {29'b0, IRQ}, 32'd2);

      // Reset mid-ACTIVE, with a bus write that must be ignored.
      rst_n = 1'b0;
      applyStimulus(OFF_MASK, 32'h7F);
      checkOutput("t6_irq", {29'b0, IRQ}, 32'd0);
      checkReg("t6_pending", OFF_PENDING, 32'h00);
      checkReg("t6_mask", OFF_MASK, 32'h00);
      checkReg("t6_status", OFF_STATUS, 32'h00);

      // Source already high at reset release registers an edge after
      // 1 + LAT edges; the address low bits are ignored on reads.
      src = 7'h01;
      step();
      rst_n = 1'b1;
      repeat (LAT) step();
      checkReg("t7_pending_early", OFF_PENDING, 32'h00);
      step();
      checkReg("t7_pending", OFF_PENDING, 32'h01);
      src = '0;
      dmem_addr = BASE | 32'h3;
      #1;
      checkOutput("t7_lowbits_rd", rd_data, 32'h01);
      dmem_addr = '0;
      checkReg("t7_eoi_rd", OFF_EOI, 32'h0);

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
